// File: rtl/pwl_vdrv.sv
// pwl_vdrv: piecewise-linear voltage driver with bounded slew.
// Ramps toward clamped target codes and pulses done after settling.
module pwl_vdrv #(
    parameter int  N_CODE     = 8,
    parameter real VLSB       = 0.01,
    parameter real VMAX       = 1.5,
    parameter int  SLEW_STEPS = 4,
    parameter int  SETTLE_CYC = 3,
    parameter real TCLK       = 1e-9
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    input  logic [N_CODE-1:0]    req_code,
    output logic                 req_ready,
    // {t0 edge index[31:0], slope in LSB/clk (signed), value in LSB}
    output logic [2*N_CODE+32:0] v_out,
    output logic [N_CODE-1:0]    cur_code,
    output logic                 busy,
    output logic                 done
);

    localparam int CODE_MAX = (1 << N_CODE) - 1;
    // Small epsilon keeps e.g. 1.5/0.01 from flooring to 149.
    localparam int KMAX_RAW = $rtoi(VMAX / VLSB + 1.0e-6);
    localparam int KMAX_INT = (KMAX_RAW > CODE_MAX) ? CODE_MAX :
                              ((KMAX_RAW < 0) ? 0 : KMAX_RAW);
    localparam int SLEW_INT = (SLEW_STEPS > CODE_MAX) ? CODE_MAX
                                                      : SLEW_STEPS;
    localparam int CW       = $clog2(SETTLE_CYC + 1);

    localparam logic [N_CODE-1:0] KMAX = N_CODE'(KMAX_INT);
    localparam logic [N_CODE-1:0] SLEW = N_CODE'(SLEW_INT);
    localparam logic [CW-1:0]     LAST = CW'(SETTLE_CYC - 1);

    if (SLEW_STEPS < 1 || SETTLE_CYC < 1 || TCLK <= 0.0 || VLSB <= 0.0)
    begin : g_bad_cfg
        $error("pwl_vdrv: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_e;

    state_e                state_q, state_d;
    logic [N_CODE-1:0]     cur_q, cur_d;
    logic [N_CODE-1:0]     tgt_q, tgt_d;
    logic [N_CODE-1:0]     pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic signed [N_CODE:0] slope_q, slope_d;
    logic [31:0]           t0_q;

    logic                  xfer;
    logic [N_CODE-1:0]     req_clamped;
    logic [N_CODE-1:0]     load_code;
    logic [N_CODE-1:0]     ramp_mag;
    logic [N_CODE-1:0]     ramp_next;
    logic [N_CODE-1:0]     plan_mag;

    // Step magnitude toward b, limited to the slew rate.
    function automatic logic [N_CODE-1:0] mag_f(
        input logic [N_CODE-1:0] a,
        input logic [N_CODE-1:0] b
    );
        logic [N_CODE-1:0] d;
        d = (a > b) ? (a - b) : (b - a);
        return (d > SLEW) ? SLEW : d;
    endfunction

    assign req_ready   = rstn & ~pend_vld_q;
    assign xfer        = req_valid & req_ready;
    assign req_clamped = (req_code > KMAX) ? KMAX : req_code;
    assign ramp_mag    = mag_f(cur_q, tgt_q);
    assign ramp_next   = (tgt_q > cur_q) ? (cur_q + ramp_mag)
                                         : (cur_q - ramp_mag);

    // Next-state logic: target latching, ramp stepping, settle count.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        tgt_d      = tgt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        load_code  = pend_vld_q ? pend_q : req_clamped;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    tgt_d   = req_clamped;
                    cnt_d   = '0;
                    state_d = (req_clamped == cur_q) ? SETTLE : RAMP;
                end
            end
            RAMP: begin
                cur_d = ramp_next;
                if (xfer) begin
                    pend_vld_d = 1'b1;
                    pend_d     = req_clamped;
                end
                if (ramp_next == tgt_q) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == LAST) begin
                    done_d = 1'b1;
                    // A request arriving now bypasses the slot.
                    if (pend_vld_q || xfer) begin
                        pend_vld_d = 1'b0;
                        tgt_d      = load_code;
                        cnt_d      = '0;
                        state_d    = (load_code == cur_q) ? SETTLE : RAMP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (xfer) begin
                        pend_vld_d = 1'b1;
                        pend_d     = req_clamped;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slope of the new segment is the step planned for the next edge.
    always_comb begin
        plan_mag = mag_f(cur_d, tgt_d);
        slope_d  = '0;
        if (state_d == RAMP) begin
            slope_d = (tgt_d > cur_d) ?  $signed({1'b0, plan_mag})
                                      : -$signed({1'b0, plan_mag});
        end
    end

    // State and segment registers; reset drops the output to 0 at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            tgt_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            slope_q    <= '0;
            t0_q       <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            slope_q    <= slope_d;
            t0_q       <= t0_q + 32'd1;
        end
    end

    assign v_out    = {t0_q, slope_q, cur_q};
    assign cur_code = cur_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_pwl_vdrv.sv
// tb_pwl_vdrv: table-driven directed bench for pwl_vdrv.
// Expected codes, slopes and flags are hand-computed per edge.
module tb_pwl_vdrv;

    localparam real VLSB = 0.01;
    localparam real TCLK = 1e-9;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic [7:0]  req_code;
    logic        req_ready;
    logic [48:0] v_out;
    logic [7:0]  cur_code;
    logic        busy;
    logic        done;

    logic [7:0]        val;
    logic signed [8:0] slp;
    logic [31:0]       t0f;

    assign val = v_out[7:0];
    assign slp = v_out[16:8];
    assign t0f = v_out[48:17];

    pwl_vdrv dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready),
        .v_out     (v_out),
        .cur_code  (cur_code),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic v;
        int   code;
        int   cur;
        int   slope;
        logic busy;
        logic done;
        logic rdy;
    } vec_t;

    vec_t tab[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_t0 = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic v, input int code, input int cur,
                       input int slope, input logic b, input logic d,
                       input logic r);
        vec_t e;
        e.v = v; e.code = code; e.cur = cur; e.slope = slope;
        e.busy = b; e.done = d; e.rdy = r;
        tab.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exp_t0++;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            req_valid = tab[i].v;
            req_code  = 8'(tab[i].code);
            tick();
            chk($sformatf("row%0d cur", i), int'(cur_code), tab[i].cur);
            chk($sformatf("row%0d val", i), int'(val), tab[i].cur);
            chk($sformatf("row%0d slope", i), int'(slp), tab[i].slope);
            chk($sformatf("row%0d busy", i), int'(busy), int'(tab[i].busy));
            chk($sformatf("row%0d done", i), int'(done), int'(tab[i].done));
            chk($sformatf("row%0d ready", i), int'(req_ready),
                int'(tab[i].rdy));
            chk($sformatf("row%0d t0", i), int'(t0f), exp_t0);
        end
        req_valid = 1'b0;
    endtask

    task automatic settle3(input string nm);
        for (int j = 1; j <= 3; j++) begin
            tick();
            chk($sformatf("%s done%0d", nm, j), int'(done), (j == 3) ? 1 : 0);
        end
        chk({nm, " idle"}, int'(busy), 0);
    endtask

    int a_end, b_end, c_end;

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_code  = '0;

        // Sequence A: 0 -> 10
        add(1, 10,  0, 4, 1, 0, 1);
        add(0,  0,  4, 4, 1, 0, 1);
        add(0,  0,  8, 2, 1, 0, 1);
        add(0,  0, 10, 0, 1, 0, 1);
        add(0,  0, 10, 0, 1, 0, 1);
        add(0,  0, 10, 0, 1, 0, 1);
        add(0,  0, 10, 0, 0, 1, 1);
        add(0,  0, 10, 0, 0, 0, 1);
        a_end = tab.size();
        // Sequence B: pending slot, held-off third request
        add(1, 11,  3, 4, 1, 0, 1);
        add(1, 20,  7, 4, 1, 0, 0);
        add(1, 50, 11, 0, 1, 0, 0);
        add(1, 50, 11, 0, 1, 0, 0);
        add(1, 50, 11, 0, 1, 0, 0);
        add(1, 50, 11, 4, 1, 1, 1);
        add(1, 50, 15, 4, 1, 0, 0);
        add(0,  0, 19, 1, 1, 0, 0);
        add(0,  0, 20, 0, 1, 0, 0);
        add(0,  0, 20, 0, 1, 0, 0);
        add(0,  0, 20, 0, 1, 0, 0);
        add(0,  0, 20, 4, 1, 1, 1);
        for (int c = 24; c <= 44; c += 4) add(0, 0, c, 4, 1, 0, 1);
        add(0,  0, 48, 2, 1, 0, 1);
        add(0,  0, 50, 0, 1, 0, 1);
        add(0,  0, 50, 0, 1, 0, 1);
        add(0,  0, 50, 0, 1, 0, 1);
        add(0,  0, 50, 0, 0, 1, 1);
        // equal request, then request landing on the done edge
        add(1, 50, 50, 0, 1, 0, 1);
        add(0,  0, 50, 0, 1, 0, 1);
        add(0,  0, 50, 0, 1, 0, 1);
        add(0,  0, 50, 0, 0, 1, 1);
        add(1, 50, 50, 0, 1, 0, 1);
        add(0,  0, 50, 0, 1, 0, 1);
        add(0,  0, 50, 0, 1, 0, 1);
        add(1, 54, 50, 4, 1, 1, 1);
        add(0,  0, 54, 0, 1, 0, 1);
        add(0,  0, 54, 0, 1, 0, 1);
        add(0,  0, 54, 0, 1, 0, 1);
        add(0,  0, 54, 0, 0, 1, 1);
        b_end = tab.size();
        // Sequence C: after mid-ramp reset, 0 -> 7
        add(1,  7,  0, 4, 1, 0, 1);
        add(0,  0,  4, 3, 1, 0, 1);
        add(0,  0,  7, 0, 1, 0, 1);
        add(0,  0,  7, 0, 1, 0, 1);
        add(0,  0,  7, 0, 1, 0, 1);
        add(0,  0,  7, 0, 0, 1, 1);
        add(0,  0,  7, 0, 0, 0, 1);
        c_end = tab.size();

        // reset state
        #2;
        chk("rst cur", int'(cur_code), 0);
        chk("rst val", int'(val), 0);
        chk("rst slope", int'(slp), 0);
        chk("rst t0", int'(t0f), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst ready", int'(req_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        exp_t0 = 0;
        #1;
        chk("rel ready", int'(req_ready), 1);

        run_rows(0, a_end);

        // clamp: 200 -> 150
        req_valid = 1'b1;
        req_code  = 8'd200;
        tick();
        req_valid = 1'b0;
        chk("clamp acc cur", int'(cur_code), 10);
        chk("clamp acc slope", int'(slp), 4);
        chk("clamp slope MVps", $rtoi(slp * VLSB / TCLK / 1.0e6 + 0.5), 40);
        for (int k = 1; k <= 35; k++) begin
            tick();
            chk($sformatf("up k%0d cur", k), int'(cur_code), 10 + 4 * k);
            chk($sformatf("up k%0d slope", k), int'(slp), (k < 35) ? 4 : 0);
        end
        settle3("up");
        repeat (2) tick();
        chk("clamp hold", int'(cur_code), 150);
        chk("vmax mV", $rtoi(val * VLSB * 1000.0 + 0.5), 1500);

        // down-ramp 150 -> 3
        req_valid = 1'b1;
        req_code  = 8'd3;
        tick();
        req_valid = 1'b0;
        chk("dn acc slope", int'(slp), -4);
        for (int k = 1; k <= 37; k++) begin
            tick();
            chk($sformatf("dn k%0d cur", k), int'(cur_code),
                (k <= 36) ? 150 - 4 * k : 3);
            chk($sformatf("dn k%0d slope", k), int'(slp),
                (k <= 35) ? -4 : ((k == 36) ? -3 : 0));
        end
        settle3("dn");

        run_rows(a_end, b_end);

        // reset while idle, then reset mid-ramp at 40
        rstn = 1'b0;
        #1;
        chk("rst2 cur", int'(cur_code), 0);
        @(negedge clk);
        rstn   = 1'b1;
        exp_t0 = 0;
        req_valid = 1'b1;
        req_code  = 8'd100;
        tick();
        req_code  = 8'd77;
        tick();
        req_valid = 1'b0;
        chk("mid slot full", int'(req_ready), 0);
        repeat (9) tick();
        chk("mid cur40", int'(cur_code), 40);
        chk("mid busy", int'(busy), 1);
        #3;
        rstn = 1'b0;
        #1;
        chk("mid rst cur", int'(cur_code), 0);
        chk("mid rst val", int'(val), 0);
        chk("mid rst slope", int'(slp), 0);
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst ready", int'(req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        rstn   = 1'b1;
        exp_t0 = 0;
        #1;
        chk("mid rel ready", int'(req_ready), 1);

        run_rows(b_end, c_end);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
